// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: actuated two-road phase sequencer; define PED_WALK_EN to add the pedestrian walk phase
module traffic_phase_scheduler #(
  parameter int GREEN_MIN = 8,
  parameter int GREEN_MAX = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 6,
  parameter int CW        = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ta,
  input  logic       tb,
`ifdef PED_WALK_EN
  input  logic       ped_req,
  output logic       walk,
`endif
  output logic [1:0] la,
  output logic [1:0] lb,
  output logic [2:0] phase,
  output logic       maxout
);
  typedef enum logic [2:0] {
    A_GREEN = 3'd0, A_YELLOW = 3'd1, AR_AB = 3'd2, B_GREEN = 3'd3,
    B_YELLOW = 3'd4, AR_BA = 3'd5, PED_WALK = 3'd6
  } state_t;
`ifdef PED_WALK_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif
  localparam logic [CW-1:0] GMIN = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] GMAX = CW'(GREEN_MAX - 1);
  localparam logic [CW-1:0] YEL  = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] ARD  = CW'(ALLRED_T - 1);
  localparam logic [CW-1:0] WLK  = CW'(WALK_T - 1);
  state_t state, nxt, cur;
  logic [CW-1:0] timer;
  logic req_a, req_b, ped_pend, ped_dir, pr;
  logic dem_a, dem_b, go_a, go_b, max_a, max_b, green;
`ifdef PED_WALK_EN
  assign pr = ped_req;
  assign walk = cur == PED_WALK;
`else
  assign pr = 1'b0;
`endif
  // a pending pedestrian request counts as cross-road demand for either green
  assign dem_b = req_b | ped_pend;
  assign dem_a = req_a | ped_pend;
  assign go_a  = dem_b && ((timer >= GMIN && !ta) || timer == GMAX);
  assign go_b  = dem_a && ((timer >= GMIN && !tb) || timer == GMAX);
  assign max_a = dem_b && ta && timer == GMAX;
  assign max_b = dem_a && tb && timer == GMAX;
  assign green = state == A_GREEN || state == B_GREEN;
  // outputs show the reset state while reset is held, otherwise decode the state register
  assign cur    = reset ? A_GREEN : state;
  assign la     = cur == A_GREEN ? 2'b00 : cur == A_YELLOW ? 2'b01 : 2'b10;
  assign lb     = cur == B_GREEN ? 2'b00 : cur == B_YELLOW ? 2'b01 : 2'b10;
  assign phase  = cur;
  assign maxout = !reset && ((state == A_GREEN && max_a) || (state == B_GREEN && max_b));
  // next-state selection; unused codes fall back to A_GREEN
  always_comb begin
    case (state)
      A_GREEN:  nxt = go_a ? A_YELLOW : A_GREEN;
      A_YELLOW: nxt = timer == YEL ? (ped_pend ? PED_WALK : AR_AB) : A_YELLOW;
      AR_AB:    nxt = timer == ARD ? B_GREEN : AR_AB;
      B_GREEN:  nxt = go_b ? B_YELLOW : B_GREEN;
      B_YELLOW: nxt = timer == YEL ? (ped_pend ? PED_WALK : AR_BA) : B_YELLOW;
      AR_BA:    nxt = timer == ARD ? A_GREEN : AR_BA;
      PED_WALK: nxt = !PED ? A_GREEN : timer == WLK ? (ped_dir ? AR_BA : AR_AB) : PED_WALK;
      default:  nxt = A_GREEN;
    endcase
  end
  // state, interval timer and demand latches; entry-clear beats a simultaneous set
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= A_GREEN;
      timer    <= '0;
      req_a    <= 1'b0;
      req_b    <= 1'b0;
      ped_pend <= 1'b0;
      ped_dir  <= 1'b0;
    end else begin
      state    <= nxt;
      timer    <= nxt != state ? '0 : (green && timer == GMAX) ? timer : timer + CW'(1);
      req_a    <= (nxt == A_GREEN && state != A_GREEN) ? 1'b0 : req_a | (ta && state != A_GREEN);
      req_b    <= (nxt == B_GREEN && state != B_GREEN) ? 1'b0 : req_b | (tb && state != B_GREEN);
      ped_pend <= (nxt == PED_WALK && state != PED_WALK) ? 1'b0 : ped_pend | pr;
      if (nxt == PED_WALK && state != PED_WALK) ped_dir <= state == B_YELLOW;
    end
  end
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler: directed scenario bench for traffic_phase_scheduler
module tb_traffic_phase_scheduler;
  logic clk = 1'b0, reset = 1'b1, ta = 1'b0, tb = 1'b0;
  logic [1:0] la, lb;
  logic [2:0] phase;
  logic maxout;
  int errors = 0, checks = 0;
`ifdef PED_WALK_EN
  logic ped_req = 1'b0, walk;
`endif
  always #5 clk = ~clk;
  traffic_phase_scheduler dut (
    .clk(clk), .reset(reset), .ta(ta), .tb(tb),
`ifdef PED_WALK_EN
    .ped_req(ped_req), .walk(walk),
`endif
    .la(la), .lb(lb), .phase(phase), .maxout(maxout)
  );
  // leaves the bench at mid-cycle 0, the first cycle after the reset edge
  task automatic do_reset(input logic a, input logic b);
    @(negedge clk);
    reset = 1'b1;
    ta = a;
    tb = b;
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_reset;
    #1;
    checks++;
    if ({la, lb, phase, maxout} !== 8'b00_10_000_0) begin
      errors++;
      $display("FAIL reset_hold got=%b expected=%b", {la, lb, phase, maxout}, 8'b00_10_000_0);
    end
    do_reset(1'b0, 1'b0);
    checks++;
    if ({la, lb, phase, maxout} !== 8'b00_10_000_0) begin
      errors++;
      $display("FAIL reset_release got=%b expected=%b", {la, lb, phase, maxout}, 8'b00_10_000_0);
    end
  endtask
  task automatic test_rest;
    do_reset(1'b1, 1'b0);
    for (int c = 0; c < 50; c++) begin
      checks++;
      if ({la, lb, maxout} !== 5'b00_10_0) begin
        errors++;
        $display("FAIL rest c=%0d got=%b expected=%b", c, {la, lb, maxout}, 5'b00_10_0);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_demand;
    logic [3:0] exp;
    do_reset(1'b0, 1'b0);
    for (int c = 0; c < 16; c++) begin
      exp[3:2] = c <= 7 ? 2'b00 : c <= 10 ? 2'b01 : 2'b10;
      exp[1:0] = c >= 12 ? 2'b00 : 2'b10;
      checks++;
      if ({la, lb} !== exp) begin
        errors++;
        $display("FAIL demand c=%0d la_lb=%b expected=%b", c, {la, lb}, exp);
      end
      if (c == 11) begin
        checks++;
        if (phase !== 3'd2) begin
          errors++;
          $display("FAIL demand_allred phase=%0d expected=2", phase);
        end
      end
      tb = c == 2;
      @(negedge clk);
    end
  endtask
  task automatic test_maxout;
    logic [2:0] exp;
    do_reset(1'b1, 1'b1);
    for (int c = 0; c < 21; c++) begin
      exp = {c <= 19 ? 2'b00 : 2'b01, c == 19 ? 1'b1 : 1'b0};
      checks++;
      if ({la, maxout} !== exp) begin
        errors++;
        $display("FAIL maxout c=%0d la_maxout=%b expected=%b", c, {la, maxout}, exp);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_reset_mid;
    do_reset(1'b0, 1'b1);
    for (int c = 0; c < 21; c++) begin
      if (c == 19 || c == 20) begin
        checks++;
        if (phase !== (c == 19 ? 3'd3 : 3'd4)) begin
          errors++;
          $display("FAIL mid_phase c=%0d phase=%0d expected=%0d", c, phase, c == 19 ? 3 : 4);
        end
      end
      tb = c == 0 || c == 20;
      ta = c == 12;
      @(negedge clk);
    end
    checks++;
    if (phase !== 3'd4) begin
      errors++;
      $display("FAIL mid_before phase=%0d expected=4", phase);
    end
    reset = 1'b1;
    ta = 1'b0;
    tb = 1'b0;
    #1;
    checks++;
    if ({la, lb, phase} !== 7'b00_10_000) begin
      errors++;
      $display("FAIL mid_during got=%b expected=%b", {la, lb, phase}, 7'b00_10_000);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 25; c++) begin
      checks++;
      if ({la, lb, phase} !== 7'b00_10_000) begin
        errors++;
        $display("FAIL mid_after c=%0d got=%b expected=%b", c, {la, lb, phase}, 7'b00_10_000);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_b_rest;
    logic [2:0] exp;
    do_reset(1'b0, 1'b1);
    for (int c = 0; c < 43; c++) begin
      exp = {c < 12 ? 2'b10 : c <= 41 ? 2'b00 : 2'b01, c == 41 ? 1'b1 : 1'b0};
      checks++;
      if ({lb, maxout} !== exp) begin
        errors++;
        $display("FAIL b_rest c=%0d lb_maxout=%b expected=%b", c, {lb, maxout}, exp);
      end
      ta = c == 40;
      @(negedge clk);
    end
  endtask
`ifdef PED_WALK_EN
  task automatic test_ped_walk;
    logic [4:0] exp;
    do_reset(1'b0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      exp[4:3] = c <= 7 ? 2'b00 : c <= 10 ? 2'b01 : 2'b10;
      exp[2:1] = c >= 18 ? 2'b00 : 2'b10;
      exp[0]   = c >= 11 && c <= 16;
      checks++;
      if ({la, lb, walk} !== exp) begin
        errors++;
        $display("FAIL ped c=%0d la_lb_walk=%b expected=%b", c, {la, lb, walk}, exp);
      end
      ped_req = c == 1;
      @(negedge clk);
    end
  endtask
`endif
  initial begin
    test_reset;
    test_rest;
    test_demand;
    test_maxout;
    test_reset_mid;
    test_b_rest;
`ifdef PED_WALK_EN
    test_ped_walk;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
